// File: rtl/cnt_frame_rx.sv
// cnt_frame_rx: receiver for the two-byte counter telemetry stream.
// It rebuilds 10-bit counter values from a high byte {6'b0, cnt[9:8]}
// followed by a low byte cnt[7:0], and offers each value on a valid/ready
// output. Malformed high bytes, inter-byte timeouts and overwritten values
// are flagged and counted.
// Optional build macro CNT_FRAME_RX_DUP_CHECK_EN adds a dup_err port. With it,
// a frame that repeats the last accepted value is dropped as a duplicate.
module cnt_frame_rx #(
  parameter int CLK_FREQ      = 12_000_000,
  parameter int BAUD          = 115200,
  parameter int TIMEOUT_BYTES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_ready,
  input  logic [7:0] rx_data,
  output logic [9:0] cnt_value,
  output logic       cnt_valid,
  input  logic       cnt_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic [7:0] err_count
`ifdef CNT_FRAME_RX_DUP_CHECK_EN
  ,
  output logic       dup_err
`endif
);

  // The product is formed in 64 bits so that faster clocks cannot overflow it.
  localparam longint TIMEOUT_L   = longint'(TIMEOUT_BYTES) * 64'd10 * longint'(CLK_FREQ)
                                   / longint'(BAUD);
  localparam int     TIMEOUT_CYC = int'(TIMEOUT_L);
  localparam int     TMR_W       = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

  typedef enum logic {
    IDLE    = 1'b0,
    WAIT_LO = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [1:0]       hi_q, hi_nxt;
  logic [TMR_W-1:0] tmr_q, tmr_nxt;
  logic             frame_done;
  logic [9:0]       frame_val;
  logic             frame_err_nxt;
  logic             dup_evt;
  logic             load;
  logic             overrun_nxt;
  logic             valid_nxt;
  logic             err_evt;

  // Frame FSM: accept the high byte, then wait for the low byte or a timeout.
  always_comb begin
    state_nxt     = state;
    hi_nxt        = hi_q;
    tmr_nxt       = tmr_q;
    frame_done    = 1'b0;
    frame_val     = {hi_q, rx_data};
    frame_err_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (rx_ready) begin
          if (rx_data[7:2] == 6'd0) begin
            hi_nxt    = rx_data[1:0];
            tmr_nxt   = '0;
            state_nxt = WAIT_LO;
          end else begin
            // A high byte with bits set above bit 1 is discarded so the
            // receiver can resynchronise on the next byte.
            frame_err_nxt = 1'b1;
          end
        end
      end
      WAIT_LO: begin
        if (rx_ready) begin
          // A low byte that arrives on the final timer cycle still completes
          // the frame.
          frame_done = 1'b1;
          hi_nxt     = 2'd0;
          state_nxt  = IDLE;
        end else if (tmr_q == TMR_LAST) begin
          frame_err_nxt = 1'b1;
          hi_nxt        = 2'd0;
          tmr_nxt       = '0;
          state_nxt     = IDLE;
        end else begin
          tmr_nxt = tmr_q + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

`ifdef CNT_FRAME_RX_DUP_CHECK_EN
  logic seen_q;
  // Duplicate detection is active only after one value has been accepted.
  assign dup_evt = frame_done && seen_q && (frame_val == cnt_value);
`else
  assign dup_evt = 1'b0;
`endif

  // Output handshake: decide whether to load, overwrite or consume this cycle.
  always_comb begin
    load        = frame_done && !dup_evt;
    overrun_nxt = load && cnt_valid && !cnt_ready;
    valid_nxt   = cnt_valid;
    if (load) begin
      valid_nxt = 1'b1;
    end else if (cnt_valid && cnt_ready) begin
      valid_nxt = 1'b0;
    end
    // At most one of these events can occur in a cycle, so the count never
    // needs to step by more than one.
    err_evt = frame_err_nxt || overrun_nxt || dup_evt;
  end

  // FSM state, latched high bits and the inter-byte timer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      hi_q  <= 2'd0;
      tmr_q <= '0;
    end else begin
      state <= state_nxt;
      hi_q  <= hi_nxt;
      tmr_q <= tmr_nxt;
    end
  end

  // Output value, valid flag, error pulses and the saturating error count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_value <= 10'd0;
      cnt_valid <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      err_count <= 8'd0;
    end else begin
      if (load) begin
        cnt_value <= frame_val;
      end
      cnt_valid <= valid_nxt;
      frame_err <= frame_err_nxt;
      overrun   <= overrun_nxt;
      if (err_evt && (err_count != 8'hFF)) begin
        err_count <= err_count + 8'd1;
      end
    end
  end

`ifdef CNT_FRAME_RX_DUP_CHECK_EN
  // Duplicate pulse, and a record that a first value has been accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dup_err <= 1'b0;
      seen_q  <= 1'b0;
    end else begin
      dup_err <= dup_evt;
      if (load) begin
        seen_q <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: doc/cnt_frame_rx.md
Name: cnt_frame_rx

Overview:
Host-side/loopback receiver for the counter telemetry stream produced by the UART transmit path. The stream sends each 10-bit counter value as two bytes: the high byte {6'b0, cnt[9:8]}, then the low byte cnt[7:0].
- Sits directly after uart_rx.
- Reassembles byte pairs into 10-bit values and presents them on a valid/ready output.
- Flags malformed frames, inter-byte timeouts and overruns.

Parameters:
CLK_FREQ, 12_000_000, clock frequency in Hz.
BAUD, 115200, UART baud rate in bit/s.
TIMEOUT_BYTES, 4, maximum gap between high and low byte, measured in byte times.

Ports:
clk  in  1  system clock; single clock domain.
rst_n  in  1  asynchronous, active-low reset.
rx_ready  in  1  single-cycle strobe from uart_rx; rx_data is valid in that cycle.
rx_data  in  8  received byte.
cnt_value  out  10  last reassembled counter value.
cnt_valid  out  1  cnt_value holds an unconsumed value.
cnt_ready  in  1  consumer accepts the value when cnt_valid && cnt_ready.
frame_err  out  1  one-cycle pulse on a bad high byte or on timeout.
overrun  out  1  one-cycle pulse when an unconsumed value is overwritten.
err_count  out  8  saturating count of frame_err plus overrun events.

Behaviour:
- Reset (rst_n=0, async): FSM=IDLE, cnt_value=0, cnt_valid=0, frame_err=0, overrun=0, err_count=0, timeout counter=0, high-byte latch=0. Reset mid-frame discards the partial frame.
- TIMEOUT_CYC = TIMEOUT_BYTES*10*CLK_FREQ/BAUD, integer truncation. Defaults give 4166.
- FSM states: IDLE (expect high byte), WAIT_LO (expect low byte).
- IDLE, rx_ready:
  - If rx_data[7:2]==0: latch rx_data[1:0] as the high bits, clear the timer, go to WAIT_LO.
  - Otherwise: pulse frame_err, stay in IDLE, discard the byte (resync).
- WAIT_LO, rx_ready: any byte value is legal. Form {hi, rx_data}, load it into cnt_value on the next clock edge, set cnt_valid=1, go to IDLE.
- WAIT_LO, no rx_ready: timer increments each cycle. When the timer reaches TIMEOUT_CYC-1 without rx_ready: pulse frame_err, drop the high bits, go to IDLE. rx_ready in that same cycle takes priority; no error is raised.
- Latency: cnt_valid rises on the first clk edge after the cycle in which the low byte's rx_ready is sampled (1 cycle).
- Handshake:
  - cnt_valid falls on the edge after a cycle with cnt_valid && cnt_ready, unless a new value loads on that same edge.
  - cnt_value is stable while cnt_valid=1 and no new frame completes.
- Frame completes with cnt_valid=1:
  - cnt_ready=0: the new value overwrites the old one, cnt_valid stays 1, overrun pulses.
  - cnt_ready=1: the old value is consumed and the new one loads with no overrun.
- err_count increments by 1 for each frame_err pulse and each overrun pulse. It saturates at 255. frame_err and overrun never occur in the same cycle.
- frame_err and overrun are registered, each high for exactly one cycle.
- rx_ready is a single-cycle strobe; back-to-back strobes on consecutive cycles are handled with no loss.

Optional Feature:
CNT_FRAME_RX_DUP_CHECK_EN
- Enabled:
  - The transmitter only sends changed values, so a completed frame equal to the last accepted value is a duplicate.
  - A duplicate is dropped: cnt_value and cnt_valid are unchanged and no overrun is raised.
  - An extra output port dup_err (1 bit) pulses for one cycle; the pulse counts in err_count.
  - The comparison is disabled for the first frame after reset.
- Disabled: no dup_err port; every completed frame loads.

Test Plan:
- Reset, cnt_ready=1, bytes 0x02 then 0x5A -> cnt_value=0x25A (602), cnt_valid high 1 cycle after the second rx_ready, then low the next cycle; err_count=0.
- Byte 0x41 in IDLE, then 0x01, 0xFF -> frame_err pulse on the 0x41, err_count=1, then cnt_value=0x1FF valid.
- Byte 0x03, no further byte for 4166 cycles -> frame_err pulse, FSM back in IDLE; then 0x00, 0x07 -> cnt_value=0x007.
- cnt_ready=0: frames 0x00/0x10 then 0x00/0x11 -> overrun pulses once, cnt_value=0x011, err_count=1; raising cnt_ready clears cnt_valid.
- Drive rst_n low after high byte 0x02, release, send 0x34 -> treated as a bad high byte (frame_err); no value produced.
- Macro enabled: frames 0x01/0x00 then 0x01/0x00 -> second frame sets dup_err; cnt_valid is not re-raised after consumption; err_count=1.
